// File: rtl/ft_pkg.sv
// Shared definitions for the lockstep fault-tolerance blocks (sequencer, shadow GPR/PC, comparator).
// Latency: n/a (types and default widths only).
// Backpressure: n/a.
package ft_pkg;

   localparam int unsigned FT_ADDR_WIDTH   = 5;
   localparam int unsigned FT_DATA_WIDTH   = 32;
   localparam int unsigned FT_NUM_REGS     = 32;
   localparam int unsigned FT_HALT_TIMEOUT = 16;
   localparam int unsigned FT_ERR_THRESH   = 3;
   localparam int unsigned FT_CNT_WIDTH    = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HALT   = 3'd1,
      ST_COPY   = 3'd2,
      ST_PC     = 3'd3,
      ST_RESUME = 3'd4,
      ST_FAULT  = 3'd5
   } ft_seq_state_e;

   // States in which both cores must be held halted.
   function automatic logic ft_state_halts(input ft_seq_state_e s);
      return (s == ST_HALT) || (s == ST_COPY) || (s == ST_PC) || (s == ST_FAULT);
   endfunction

endpackage

// File: rtl/ft_recovery_seq.sv
// Purpose: lockstep recovery sequencer; gates shadow commits, halts cores on mismatch,
//          replays the shadow GPRs and PC, then resumes; flags a sticky permanent fault.
// Latency: error edge N -> halt_o from N+1; resume_o 35 cycles later with immediate acks/ready.
// Backpressure: rf_ready_i low in COPY stalls the restore stream (addr/data held), +1 cycle each.
// Ports: clk_i/rst_n; error_i, halted_{a,b}_i in; halt_o, resume_o, we_sgpr_o, we_spc_o;
//        sgpr_raddr_o/sgpr_rdata_i, spc_i; rf_valid_o/rf_ready_i/rf_waddr_o/rf_wdata_o;
//        pc_we_o/pc_o; busy_o, fault_o, err_cnt_o.
// Optional: `define FT_ERR_CNT_EN enables the recovery counter and error-rate fault.
module ft_recovery_seq
   import ft_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = FT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH   = FT_DATA_WIDTH,
   parameter int unsigned NUM_REGS     = FT_NUM_REGS,
   parameter int unsigned HALT_TIMEOUT = FT_HALT_TIMEOUT,
   parameter int unsigned ERR_THRESH   = FT_ERR_THRESH,
   parameter int unsigned CNT_WIDTH    = FT_CNT_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  error_i,
   input  logic                  halted_a_i,
   input  logic                  halted_b_i,
   output logic                  halt_o,
   output logic                  resume_o,
   output logic                  we_sgpr_o,
   output logic                  we_spc_o,
   output logic [ADDR_WIDTH-1:0] sgpr_raddr_o,
   input  logic [DATA_WIDTH-1:0] sgpr_rdata_i,
   input  logic [DATA_WIDTH-1:0] spc_i,
   output logic                  rf_valid_o,
   input  logic                  rf_ready_i,
   output logic [ADDR_WIDTH-1:0] rf_waddr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   output logic                  pc_we_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  busy_o,
   output logic                  fault_o,
   output logic [CNT_WIDTH-1:0]  err_cnt_o
);

   localparam int unsigned           TMO_W     = $clog2(HALT_TIMEOUT + 1);
   localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(HALT_TIMEOUT - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_REGS - 1);

   ft_seq_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  thresh_hit;

   logic halt_q, resume_q, rf_valid_q, pc_we_q, busy_q, fault_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      tmo_d   = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (error_i) begin
               if (thresh_hit) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_HALT;
                  tmo_d   = '0;
               end
            end
         end
         ST_HALT: begin
            // Acks in the final HALT cycle win over the timeout.
            if (halted_a_i && halted_b_i) begin
               state_d = ST_COPY;
               addr_d  = '0;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ST_FAULT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_COPY: begin
            if (rf_ready_i) begin
               if (addr_q == ADDR_LAST) begin
                  state_d = ST_PC;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_PC:     state_d = ST_RESUME;
         ST_RESUME: state_d = ST_IDLE;
         ST_FAULT:  state_d = ST_FAULT;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         tmo_q      <= '0;
         halt_q     <= 1'b0;
         resume_q   <= 1'b0;
         rf_valid_q <= 1'b0;
         pc_we_q    <= 1'b0;
         busy_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         tmo_q      <= tmo_d;
         halt_q     <= ft_state_halts(state_d);
         resume_q   <= (state_d == ST_RESUME);
         rf_valid_q <= (state_d == ST_COPY);
         pc_we_q    <= (state_d == ST_PC);
         busy_q     <= (state_d != ST_IDLE);
         fault_q    <= (state_d == ST_FAULT);
      end
   end

`ifdef FT_ERR_CNT_EN
   logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_q == ST_IDLE) && (state_d == ST_HALT) && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign thresh_hit = (32'(err_cnt_q) >= ERR_THRESH);
   assign err_cnt_o  = err_cnt_q;
`else
   logic unused_thresh;
   assign unused_thresh = ^ERR_THRESH;
   assign thresh_hit    = 1'b0;
   assign err_cnt_o     = '0;
`endif

   // A write that coincides with a mismatch must never reach the shadow copy.
   assign we_sgpr_o    = (state_q == ST_IDLE) && !error_i;
   assign we_spc_o     = (state_q == ST_IDLE) && !error_i;

   assign sgpr_raddr_o = addr_q;
   assign rf_valid_o   = rf_valid_q;
   assign rf_waddr_o   = rf_valid_q ? addr_q : '0;
   assign rf_wdata_o   = rf_valid_q ? sgpr_rdata_i : '0;
   assign pc_we_o      = pc_we_q;
   assign pc_o         = pc_we_q ? spc_i : '0;
   assign halt_o       = halt_q;
   assign resume_o     = resume_q;
   assign busy_o       = busy_q;
   assign fault_o      = fault_q;

endmodule

// File: tb/tb_ft_recovery_seq.sv
// Bench for ft_recovery_seq: scoreboard of expected restore transfers, PC and resume timing.
// Latency: n/a.
// Backpressure: rf_ready_i driven constant, random, or a fixed 3-cycle stall at address 7.
module tb_ft_recovery_seq;

   localparam int NREG = 32;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        error_i = 1'b0;
   logic        halted_a_i = 1'b1;
   logic        halted_b_i = 1'b1;
   logic        halt_o, resume_o, we_sgpr_o, we_spc_o;
   logic [4:0]  sgpr_raddr_o;
   logic [31:0] sgpr_rdata_i;
   logic [31:0] spc_i = 32'h0;
   logic        rf_valid_o;
   logic        rf_ready_i = 1'b1;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        pc_we_o;
   logic [31:0] pc_o;
   logic        busy_o, fault_o;
   logic [3:0]  err_cnt_o;

   ft_recovery_seq dut (
      .clk_i(clk_i), .rst_n(rst_n), .error_i(error_i),
      .halted_a_i(halted_a_i), .halted_b_i(halted_b_i),
      .halt_o(halt_o), .resume_o(resume_o),
      .we_sgpr_o(we_sgpr_o), .we_spc_o(we_spc_o),
      .sgpr_raddr_o(sgpr_raddr_o), .sgpr_rdata_i(sgpr_rdata_i), .spc_i(spc_i),
      .rf_valid_o(rf_valid_o), .rf_ready_i(rf_ready_i),
      .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .pc_we_o(pc_we_o), .pc_o(pc_o),
      .busy_o(busy_o), .fault_o(fault_o), .err_cnt_o(err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Shadow GPR array with combinational read.
   logic [31:0] mem [NREG];
   always_comb sgpr_rdata_i = mem[sgpr_raddr_o];

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } xfer_t;

   xfer_t       xq[$];
   logic [31:0] pq[$];
   int          rq[$];
   int          cur_stalls = 0;
   int          last_stalls = 0;
   bit          prev_stall = 0;
   logic [4:0]  prev_a;
   logic [31:0] prev_d;

   // Monitor: samples on the falling edge, pops expectations as the DUT presents them.
   initial begin
      forever begin
         @(negedge clk_i);
         if (prev_stall) begin
            chk("valid_held", rf_valid_o, 1'b1);
            chk("addr_held", rf_waddr_o, prev_a);
            chk("data_held", rf_wdata_o, prev_d);
         end
         prev_stall = 0;
         if (rf_valid_o) begin
            if (rf_ready_i) begin
               if (xq.size() == 0) begin
                  chk("unexpected_xfer", 1'b1, 1'b0);
               end else begin
                  xfer_t e;
                  e = xq.pop_front();
                  chk("xfer_addr", rf_waddr_o, e.a);
                  chk("xfer_data", rf_wdata_o, e.d);
               end
            end else begin
               cur_stalls++;
               prev_stall = 1;
               prev_a = rf_waddr_o;
               prev_d = rf_wdata_o;
            end
         end
         if (pc_we_o) begin
            if (pq.size() == 0) chk("unexpected_pc_we", 1'b1, 1'b0);
            else                chk("pc_value", pc_o, pq.pop_front());
         end
         if (resume_o) begin
            if (rq.size() == 0) begin
               chk("unexpected_resume", 1'b1, 1'b0);
            end else begin
               int base;
               base = rq.pop_front();
               chk("resume_cycle", cyc, base + cur_stalls);
            end
            last_stalls = cur_stalls;
            cur_stalls  = 0;
         end
      end
   end

   // rf_ready_i driver: 0 = always ready, 1 = random, 2 = three-cycle stall at address 7.
   int rdy_mode = 0;
   int bp_left  = 0;
   initial begin
      forever begin
         @(posedge clk_i);
         #1;
         case (rdy_mode)
            1: rf_ready_i = ($urandom_range(0, 3) != 0);
            2: begin
               if (rf_valid_o && rf_waddr_o == 5'd7 && bp_left > 0) begin
                  rf_ready_i = 1'b0;
                  bp_left--;
               end else begin
                  rf_ready_i = 1'b1;
               end
            end
            default: rf_ready_i = 1'b1;
         endcase
      end
   end

   task automatic flush();
      xq.delete();
      pq.delete();
      rq.delete();
      cur_stalls = 0;
      prev_stall = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      error_i = 1'b0;
      halted_a_i = 1'b1;
      halted_b_i = 1'b1;
      flush();
      repeat (2) @(posedge clk_i);
      #1;
      rst_n = 1'b1;
   endtask

   // Loads the shadow array/PC and queues the expected restore stream; called at posedge+1.
   task automatic load_and_expect(input bit fixed);
      for (int i = 0; i < NREG; i++) begin
         mem[i] = fixed ? (32'hA5A5_0000 + 32'(i)) : $urandom;
         xq.push_back('{a: 5'(i), d: mem[i]});
      end
      spc_i = fixed ? 32'h0000_0180 : ($urandom & 32'hFFFF_FFFC);
      pq.push_back(spc_i);
      // Error sampled at edge N = cyc+1; the RESUME cycle starts at edge N+34,
      // i.e. the 35th cycle counted from the HALT cycle as cycle N+1.
      rq.push_back(cyc + 1 + 34);
   endtask

   task automatic wait_idle(input bit noisy);
      bit done = 0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(posedge clk_i);
         #1;
         if (noisy) begin
            if (busy_o) chk("commit_gated_busy", {we_sgpr_o, we_spc_o}, 2'b00);
            error_i = rf_valid_o ? 1'($urandom_range(0, 1)) : 1'b0;
         end else begin
            error_i = 1'b0;
         end
         if (!busy_o) done = 1;
      end
      if (!done) chk("idle_timeout", 1'b1, 1'b0);
      chk("all_xfers_seen", xq.size(), 0);
      chk("all_resumes_seen", rq.size(), 0);
   endtask

   task automatic recover(input int rmode, input bit fixed, input bit noisy);
      rdy_mode = rmode;
      load_and_expect(fixed);
      error_i = 1'b1;
      #1;
      chk("we_sgpr_gated", we_sgpr_o, 1'b0);
      chk("we_spc_gated", we_spc_o, 1'b0);
      wait_idle(noisy);
   endtask

   initial begin
      for (int i = 0; i < NREG; i++) mem[i] = 32'h0;
      rst_n = 1'b0;
      #1;
      chk("rst_halt", halt_o, 1'b0);
      chk("rst_ctrl", {resume_o, rf_valid_o, pc_we_o, fault_o, busy_o}, 5'b0);
      chk("rst_err_cnt", err_cnt_o, 4'd0);
      chk("rst_data", {rf_waddr_o, rf_wdata_o, pc_o}, 69'd0);
      do_reset();
      chk("idle_commit_en", {we_sgpr_o, we_spc_o}, 2'b11);

      // Basic recovery: fixed pattern, immediate acks and ready.
      recover(0, 1'b1, 1'b0);
      chk("basic_no_stall", last_stalls, 0);

      // Backpressure: 3 stall cycles at address 7.
      do_reset();
      bp_left = 3;
      recover(2, 1'b1, 1'b0);
      chk("bp_stalls", last_stalls, 3);

      // Commit gating with error noise during COPY; only one recovery must occur.
      do_reset();
      recover(0, 1'b0, 1'b1);
      repeat (5) @(posedge clk_i);
      #1;
      chk("noise_ignored_busy", busy_o, 1'b0);

      // Random recoveries, then a fourth error.
      do_reset();
      for (int r = 0; r < 3; r++) begin
         @(posedge clk_i);
         #1;
         recover(1, 1'b0, 1'b0);
      end
`ifdef FT_ERR_CNT_EN
      chk("err_cnt_3", err_cnt_o, 4'd3);
      error_i = 1'b1;
      @(posedge clk_i);
      #1;
      error_i = 1'b0;
      chk("thresh_fault", fault_o, 1'b1);
      chk("thresh_no_copy", rf_valid_o, 1'b0);
      chk("thresh_halt", halt_o, 1'b1);
`else
      chk("err_cnt_tied", err_cnt_o, 4'd0);
      @(posedge clk_i);
      #1;
      recover(1, 1'b0, 1'b0);
      chk("fourth_no_fault", fault_o, 1'b0);
`endif

      // Halt timeout: core B never acknowledges.
      do_reset();
      halted_b_i = 1'b0;
      error_i = 1'b1;
      repeat (16) begin
         @(posedge clk_i);
         #1;
         error_i = 1'b0;
      end
      chk("tmo_last_halt", {halt_o, fault_o}, 2'b10);
      @(posedge clk_i);
      #1;
      chk("tmo_fault", fault_o, 1'b1);
      chk("tmo_fault_halt", halt_o, 1'b1);
      chk("tmo_fault_commits", {we_sgpr_o, we_spc_o}, 2'b00);
      repeat (20) begin
         @(posedge clk_i);
         #1;
         error_i = 1'($urandom_range(0, 1));
         halted_b_i = 1'($urandom_range(0, 1));
      end
      error_i = 1'b0;
      chk("tmo_sticky", {fault_o, halt_o, busy_o}, 3'b111);
      rst_n = 1'b0;
      #1;
      chk("tmo_reset_clear", {fault_o, halt_o, busy_o}, 3'b000);
      do_reset();

      // Mid-recovery reset at address 12.
      rdy_mode = 0;
      load_and_expect(1'b0);
      error_i = 1'b1;
      begin
         bit hit = 0;
         for (int k = 0; k < 100 && !hit; k++) begin
            @(posedge clk_i);
            #1;
            error_i = 1'b0;
            if (rf_valid_o && rf_waddr_o == 5'd12) hit = 1;
         end
         if (!hit) chk("mid_reach_addr12", 1'b0, 1'b1);
      end
      #1;
      rst_n = 1'b0;
      flush();
      #1;
      chk("mid_rst_ctrl", {halt_o, resume_o, rf_valid_o, pc_we_o, fault_o, busy_o}, 6'b0);
      chk("mid_rst_data", {rf_waddr_o, rf_wdata_o, pc_o}, 69'd0);
      chk("mid_rst_commit", we_sgpr_o, 1'b1);
      @(posedge clk_i);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("mid_rst_idle", {busy_o, resume_o}, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
